// File: rtl/trace_capture_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trace_capture_buffer_pkg
// Description : Shared state encoding and width helpers for the trace buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package trace_capture_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DUMP  = 2'd3
  } tcb_state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int tcb_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trace_capture_buffer_ram.sv
`default_nettype none
// ============================================================================
// Module      : trace_capture_buffer_ram
// Description : DEPTH x DW flop array, one write port, one async read port.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_capture_buffer_ram
  import trace_capture_buffer_pkg::*;
#(
  parameter  int DEPTH = 64,
  parameter  int DW    = 128,
  localparam int AW    = tcb_clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/trace_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module      : trace_capture_buffer
// Description : Triggered circular capture of probe words with oldest-first
//               valid/ready readout of the captured window.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_capture_buffer
  import trace_capture_buffer_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 64,
  localparam int AW       = tcb_clog2(DEPTH),
  localparam int DW       = CHANNELS * WIDTH
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [DW-1:0] i_probe_data,
  input  logic          i_probe_valid,
  input  logic          i_arm,
  input  logic          i_abort,
  input  logic          i_trig_in,
  input  logic [AW-1:0] i_post_count,
  output logic [DW-1:0] o_rd_data,
  output logic          o_rd_valid,
  input  logic          i_rd_ready,
  output logic          o_rd_last,
  output logic [1:0]    o_state,
  output logic [AW-1:0] o_trig_index,
  output logic [AW:0]   o_sample_count
);

  localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

  tcb_state_e    r_state;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_remaining;
  logic [AW-1:0] r_trig_index;
  logic [AW:0]   r_sample_count;
  logic [AW:0]   r_beats_left;
  logic          r_rd_valid;
  logic          r_rd_last;
  logic [DW-1:0] r_rd_data;

  logic          w_arm_take;
  logic          w_capturing;
  logic          w_we;
  logic [AW-1:0] w_wptr_inc;
  logic [AW:0]   w_cnt_next;
  logic [AW-1:0] w_dump_start;
  logic [DW-1:0] w_rd_word;

  always_comb begin
    w_arm_take   = i_arm && ((r_state == ST_IDLE) || (r_state == ST_ARMED));
    w_capturing  = ((r_state == ST_ARMED) && !w_arm_take) || (r_state == ST_POST);
    w_we         = !i_abort && w_capturing && i_probe_valid;
    w_wptr_inc   = r_wptr + AW'(1);
    w_cnt_next   = (r_sample_count == c_FULL) ? r_sample_count
                                              : r_sample_count + (AW+1)'(1);
    // Once the buffer has wrapped, the slot about to be overwritten is the oldest.
    w_dump_start = (w_cnt_next == c_FULL) ? w_wptr_inc : '0;
  end

  trace_capture_buffer_ram #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (i_probe_data),
    .i_raddr (r_rptr),
    .o_rdata (w_rd_word)
  );

  // An AW-bit post_count tops out at DEPTH-1, so the trigger sample is never
  // overwritten without any further clamping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= ST_IDLE;
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_remaining    <= '0;
      r_trig_index   <= '0;
      r_sample_count <= '0;
      r_beats_left   <= '0;
      r_rd_valid     <= 1'b0;
      r_rd_last      <= 1'b0;
      r_rd_data      <= '0;
    end else if (i_abort) begin
      r_state    <= ST_IDLE;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else if (w_arm_take) begin
      r_state        <= ST_ARMED;
      r_wptr         <= '0;
      r_sample_count <= '0;
    end else begin
      case (r_state)
        ST_ARMED: begin
          if (i_probe_valid) begin
            r_wptr         <= w_wptr_inc;
            r_sample_count <= w_cnt_next;
            if (i_trig_in) begin
              r_trig_index <= r_wptr;
              r_remaining  <= i_post_count;
              if (i_post_count == '0) begin
                r_state      <= ST_DUMP;
                r_rptr       <= w_dump_start;
                r_beats_left <= w_cnt_next;
              end else begin
                r_state <= ST_POST;
              end
            end
          end
        end
        ST_POST: begin
          if (i_probe_valid) begin
            r_wptr         <= w_wptr_inc;
            r_sample_count <= w_cnt_next;
            r_remaining    <= r_remaining - AW'(1);
            if (r_remaining == AW'(1)) begin
              r_state      <= ST_DUMP;
              r_rptr       <= w_dump_start;
              r_beats_left <= w_cnt_next;
            end
          end
        end
        ST_DUMP: begin
          // Initial fill, or reload on a taken beat that was not the last.
          if (!r_rd_valid || (i_rd_ready && !r_rd_last)) begin
            r_rd_data    <= w_rd_word;
            r_rd_valid   <= 1'b1;
            r_rd_last    <= (r_beats_left == (AW+1)'(1));
            r_rptr       <= r_rptr + AW'(1);
            r_beats_left <= r_beats_left - (AW+1)'(1);
          end else if (i_rd_ready) begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_rd_data      = r_rd_data;
  assign o_rd_valid     = r_rd_valid;
  assign o_rd_last      = r_rd_last;
  assign o_state        = r_state;
  assign o_trig_index   = r_trig_index;
  assign o_sample_count = r_sample_count;

endmodule
`default_nettype wire

// File: doc/trace_capture_buffer.md
Name: trace_capture_buffer

Overview:
- Parametrised on-chip logic-analyser buffer that sits beside the processor in the top-level wrapper.
- Records the pipeline-latch probe words (FD/DX/XM/MW style, any channel count) into a circular buffer, one entry per qualified cycle.
- Stops a programmable number of samples after a trigger, then streams the captured window out oldest-first over a valid/ready port.
- Replaces static debug wires with a history of up to DEPTH cycles.

Parameters:
- CHANNELS, 4: number of probe words captured per sample.
- WIDTH, 32: bits per probe word.
- DEPTH, 64: buffer entries; must be a power of two, >= 4.
- AW, log2(DEPTH): derived pointer width; not user-overridden.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- probe_data  in  CHANNELS*WIDTH  concatenated probe words; channel 0 in the LSBs.
- probe_valid  in  1  sample qualifier (e.g. ~stall); only qualified cycles are stored.
- arm  in  1  pulse: start a new capture.
- abort  in  1  pulse: return to IDLE from any state.
- trig_in  in  1  trigger, qualified by probe_valid.
- post_count  in  AW  samples to store after the trigger sample; sampled at the trigger.
- rd_data  out  CHANNELS*WIDTH  readout entry.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  consumer accepts the beat.
- rd_last  out  1  marks the final readout beat.
- state  out  2  IDLE=0, ARMED=1, POST=2, DUMP=3.
- trig_index  out  AW  buffer index of the trigger sample.
- sample_count  out  AW+1  valid entries held, saturating at DEPTH.

Behaviour:
- Reset (async, reset=0): state IDLE; wptr, rptr, remaining, sample_count, trig_index = 0; rd_valid, rd_last = 0; rd_data = 0. Buffer contents are don't-care. Applies immediately mid-capture or mid-dump.
- Priority each cycle: abort > arm > normal FSM.
- abort: next state IDLE, rd_valid=0; captured data is discarded logically.
- IDLE: nothing written.
  - arm -> ARMED; wptr=0, sample_count=0.
- ARMED:
  - On probe_valid: write mem[wptr]=probe_data; wptr++ (wraps mod DEPTH); sample_count++ saturating at DEPTH.
  - arm while ARMED restarts the capture (pointers and count cleared; the same-cycle sample is not written).
  - trig_in with probe_valid:
    - Trigger sample is written; trig_index=wptr (pre-increment).
    - remaining = min(post_count, DEPTH-1).
    - remaining==0 -> DUMP; else -> POST.
  - trig_in without probe_valid is ignored.
- POST:
  - Write on probe_valid exactly as in ARMED; remaining-- per write.
  - The write that takes remaining from 1 to 0 -> DUMP.
  - trig_in and arm are ignored.
- DUMP:
  - No writes.
  - Start index: rptr = 0 if sample_count<DEPTH, else wptr (the oldest entry).
  - rd_valid rises on the first cycle after DUMP entry; rd_data is loaded from mem[rptr] through an output register.
  - Beat transfers when rd_valid && rd_ready; the output register then reloads with the next entry in the same cycle, giving back-to-back beats with no bubble.
  - rd_data and rd_last stay stable while rd_valid && !rd_ready.
  - Exactly sample_count beats are sent; rd_last=1 on the final one.
  - After the last transfer: rd_valid=0 and the next state is IDLE. sample_count and trig_index hold until the next arm.
  - arm in DUMP is ignored; abort is honoured.
- Width rules:
  - All pointer arithmetic is mod DEPTH.
  - sample_count is AW+1 bits so the value DEPTH is representable.
  - post_count values >= DEPTH are clamped so the trigger sample is never overwritten.

Decomposition:
- Shared header trace_defs.vh holds the state encodings (IDLE/ARMED/POST/DUMP) and a clog2 helper function for AW.
- One sub-module, trace_ram: DEPTH x (CHANNELS*WIDTH) flop array with one write port and one asynchronous read port.
- FSM, pointers and the output register live in the top block.

Test Plan:
- Reset check: hold reset=0 with random inputs.
  - Required: state=0, rd_valid=0, rd_last=0, sample_count=0, trig_index=0, rd_data=0.
  - Releasing reset with no arm leaves state=0.
- Basic window (DEPTH=64): arm; probe_data=i for i=0..20, all valid; trig_in at i=5; post_count=3.
  - Required: POST after i=5; DUMP after i=8; trig_index=5; sample_count=9.
  - Readout 0..8 in order; rd_last only on value 8; then IDLE.
- Wrap-around: arm; 100 valid samples i=0..99; trigger at i=90; post_count=5.
  - Required: sample_count=64; 64 beats with values 32..95 in order; trig_index=90 mod 64=26.
- Qualifier and backpressure: probe_valid low every third cycle; post_count=0; trigger on a valid cycle; rd_ready toggles pseudo-randomly.
  - Required: gap cycles are absent from the dump.
  - DUMP is entered the cycle after the trigger.
  - No duplicated or dropped beats; rd_data stable while stalled.
- Clamp and ignore: post_count=63 with DEPTH=64; trig_in asserted again during POST; arm asserted during DUMP.
  - Required: exactly 63 post-trigger samples; the trigger sample is the first of 64 beats.
  - The second trigger and the DUMP-time arm have no effect.
- Abort and reset mid-operation: abort in POST -> IDLE next cycle, no readout.
  - Reset driven low mid-DUMP (between clock edges) -> rd_valid=0 and state=0 immediately.
  - A fresh arm then captures normally.
